gray_reader: RTL and testbench
==============================

GRAY_READER -- requirements
Module: gray_reader

Interface
REQ-001 Parameter LEN, default 10: width of the Gray-coded input and of the binary output.
REQ-002 Parameter STABLE, default 4: consecutive clocks a synchronized input value must hold before acceptance; legal range 2..255.
REQ-003 CLK  input  1  sole clock; all state on rising edge.
REQ-004 RST_N  input  1  reset; asynchronous, active-low; assertion clears all state immediately; release is synchronous to CLK.
REQ-005 GRAY  input  LEN  Gray-coded value, asynchronous to CLK; bit LEN-1 is the MSB.
REQ-006 BIN  output  LEN  binary decode of the last accepted Gray value.
REQ-007 VALID  output  1  one-cycle pulse when a new value is accepted.
REQ-008 DIR  output  1  direction of the last legal step; 1 means +1, 0 means -1.
REQ-009 STEP_ERR  output  1  one-cycle pulse, coincident with VALID, when the accepted value is not +/-1 from the previous one.
REQ-010 ERR_CNT  output  8  saturating count of STEP_ERR pulses.
REQ-011 LOCKED  output  1  high from the first acceptance after reset.

Function
REQ-012 Synchronizer: s1 <= GRAY, s2 <= s1, s3 <= s2 every clock; only s2 and s3 feed the logic.
REQ-013 Stability counter cnt, 8 bits: 0 when s2 != s3; otherwise increments, saturating at STABLE.
REQ-014 Accept condition: s2 == s3, cnt == STABLE-1, and either LOCKED == 0 or s2 differs from the held accepted Gray value.
REQ-015 On accept, all outputs update on the same edge: held Gray <= s2, BIN <= decode(s2), VALID = 1, LOCKED = 1.
REQ-016 Decode: BIN[LEN-1] = g[LEN-1]; BIN[i] = BIN[i+1] XOR g[i] for i = LEN-2..0.
REQ-017 Step check, skipped on the first acceptance after reset: d = new BIN - old BIN modulo 2^LEN.
REQ-018 d == 1 sets DIR = 1; d == 2^LEN-1 sets DIR = 0; any other d pulses STEP_ERR and leaves DIR unchanged.
REQ-019 BIN is updated to the new value even when STEP_ERR pulses, which resynchronizes the reader.
REQ-020 Wrap: 2^LEN-1 -> 0 is a legal +1 step; 0 -> 2^LEN-1 is a legal -1 step.
REQ-021 ERR_CNT increments on each STEP_ERR pulse and holds at 255.
REQ-022 Latency: a GRAY change settled before edge 1, then held, produces VALID after edge STABLE+3 (edge 7 with STABLE = 4).
REQ-023 Glitch rejection: an s2 change lasting fewer than STABLE clocks is never accepted.
REQ-024 Any s2 change inside the window restarts cnt from 0.
REQ-025 Return to the held accepted value is not re-accepted: no VALID pulse.
REQ-026 A constant input after acceptance produces no further VALID pulses, because cnt saturates at STABLE.
REQ-027 VALID and STEP_ERR are high for exactly one clock per acceptance; back-to-back acceptances are at least STABLE+1 clocks apart.

Reset
REQ-028 While RST_N = 0: s1, s2, s3, held Gray, cnt, BIN, VALID, STEP_ERR, ERR_CNT and LOCKED are 0; DIR is 1.
REQ-029 Reset asserted mid-window or mid-pulse clears immediately; after release the first acceptance is treated as initial (no step check).
REQ-030 After release with GRAY constant at 0: VALID pulses after edge STABLE, BIN = 0, LOCKED = 1, STEP_ERR = 0.

Verification
REQ-031 LEN=10, STABLE=4; release reset with GRAY = 0 -> VALID after edge 4, BIN = 0x000, LOCKED = 1, ERR_CNT = 0.
REQ-032 Drive the Gray sequence of binary 0..1023 and back to 0, holding each value 6 clocks -> 1024 VALID pulses; DIR = 1 throughout; the 1023 -> 0 step has no STEP_ERR.
REQ-033 From BIN = 5, drive Gray(4) -> VALID with DIR = 0 and BIN = 4; then drive Gray(9) -> VALID, STEP_ERR pulse, BIN = 9, ERR_CNT = 1, DIR stays 0.
REQ-034 From BIN = 5, hold Gray(6) for 2 clocks then return to Gray(5) -> no VALID, BIN stays 5; a 3-clock glitch to Gray(6) likewise produces no VALID.
REQ-035 Generate 300 illegal jumps -> ERR_CNT = 255 and holds.
REQ-036 Assert RST_N during the stability window of a pending change -> all outputs reset at once; after release the first acceptance has LOCKED rising and no STEP_ERR.

Source files
------------

// File: rtl/gray_reader.sv
// Gray-code position reader: synchronizes an async Gray bus, debounces it,
// decodes to binary and flags direction and illegal multi-step jumps.
module gray_reader #(
  parameter int LEN    = 10,
  parameter int STABLE = 4
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [LEN-1:0] GRAY,
  output logic [LEN-1:0] BIN,
  output logic           VALID,
  output logic           DIR,
  output logic           STEP_ERR,
  output logic [7:0]     ERR_CNT,
  output logic           LOCKED
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE);
  localparam logic [7:0] CNT_ACC = 8'(STABLE - 1);

  logic [LEN-1:0] s1, s2, s3;
  logic [LEN-1:0] held;
  logic [7:0]     cnt;
  logic [LEN-1:0] dec;
  logic [LEN-1:0] diff;
  logic           same;
  logic           accept;
  logic           step_up;
  logic           step_dn;

  function automatic logic [LEN-1:0] g2b(input logic [LEN-1:0] g);
    logic [LEN-1:0] b;
    b[LEN-1] = g[LEN-1];
    for (int i = LEN - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    dec     = g2b(s2);
    diff    = dec - BIN;
    same    = (s2 == s3);
    step_up = (diff == LEN'(1));
    step_dn = (diff == {LEN{1'b1}});
    accept  = same && (cnt == CNT_ACC) &&
              (!LOCKED || (s2 != held));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      held     <= '0;
      cnt      <= '0;
      BIN      <= '0;
      VALID    <= 1'b0;
      DIR      <= 1'b1;
      STEP_ERR <= 1'b0;
      ERR_CNT  <= '0;
      LOCKED   <= 1'b0;
    end else begin
      s1       <= GRAY;
      s2       <= s1;
      s3       <= s2;
      VALID    <= accept;
      STEP_ERR <= 1'b0;
      if (!same) begin
        cnt <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + 8'd1;
      end
      if (accept) begin
        held   <= s2;
        BIN    <= dec;
        LOCKED <= 1'b1;
        // first acceptance after reset has no prior position to compare
        if (LOCKED) begin
          if (step_up) begin
            DIR <= 1'b1;
          end else if (step_dn) begin
            DIR <= 1'b0;
          end else begin
            STEP_ERR <= 1'b1;
            if (ERR_CNT != 8'hFF) begin
              ERR_CNT <= ERR_CNT + 8'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_reader.sv
// Scoreboard bench for gray_reader: directed Gray steps, glitches,
// illegal jumps, saturation and mid-window reset.
module tb_gray_reader;

  localparam int LEN = 10;
  localparam int MSK = (1 << LEN) - 1;

  logic           clk;
  logic           rst_n;
  logic [LEN-1:0] gray;
  logic [LEN-1:0] bin;
  logic           valid;
  logic           dir;
  logic           step_err;
  logic [7:0]     err_cnt;
  logic           locked;

  typedef struct packed {
    logic [LEN-1:0] bin;
    logic           dir;
    logic           se;
    logic [7:0]     err;
    logic           lk;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;
  int   n_valid;
  logic prev_v;

  int   m_bin;
  int   m_dir;
  int   m_err;
  int   m_lk;

  gray_reader #(.LEN(LEN), .STABLE(4)) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .GRAY(gray),
    .BIN(bin),
    .VALID(valid),
    .DIR(dir),
    .STEP_ERR(step_err),
    .ERR_CNT(err_cnt),
    .LOCKED(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (rst_n) begin
      if (valid && prev_v) begin
        n_chk++;
        n_fail++;
        $display("FAIL valid_width: valid high 2 cycles, expected 1");
      end
      if (step_err && !valid) begin
        n_chk++;
        n_fail++;
        $display("FAIL step_err_alone: step_err=1 valid=0");
      end
      if (valid) begin
        n_valid++;
        a = '{bin, dir, step_err, err_cnt, locked};
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: got bin=%0d, expected no pulse",
                   bin);
        end else begin
          e = q.pop_front();
          if (a != e) begin
            n_fail++;
            $display("FAIL accept: got bin=%0d dir=%0d se=%0d err=%0d lk=%0d expected bin=%0d dir=%0d se=%0d err=%0d lk=%0d",
                     a.bin, a.dir, a.se, a.err, a.lk,
                     e.bin, e.dir, e.se, e.err, e.lk);
          end
        end
      end
    end
    prev_v = valid;
  end

  function automatic logic [LEN-1:0] b2g(input int b);
    logic [LEN-1:0] v;
    v = LEN'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic expect_accept(input int b);
    int   d;
    exp_t e;
    e.se = 1'b0;
    if (m_lk != 0) begin
      d = (b - m_bin) & MSK;
      if (d == 1) m_dir = 1;
      else if (d == MSK) m_dir = 0;
      else begin
        e.se = 1'b1;
        if (m_err < 255) m_err++;
      end
    end
    m_bin = b;
    m_lk  = 1;
    e.bin = LEN'(b);
    e.dir = 1'(m_dir);
    e.err = 8'(m_err);
    e.lk  = 1'b1;
    q.push_back(e);
  endtask

  task automatic drive(input int b, input int hold);
    gray = b2g(b);
    if (m_lk == 0 || b != m_bin) expect_accept(b);
    repeat (hold) @(negedge clk);
  endtask

  task automatic glitch(input int b, input int n);
    gray = b2g(b);
    repeat (n) @(negedge clk);
    gray = b2g(m_bin);
    repeat (10) @(negedge clk);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    chk(nm, q.size(), 0);
  endtask

  task automatic reset_model();
    q.delete();
    m_bin = 0;
    m_dir = 1;
    m_err = 0;
    m_lk  = 0;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_bin"}, int'(bin), 0);
    chk({nm, "_valid"}, int'(valid), 0);
    chk({nm, "_dir"}, int'(dir), 1);
    chk({nm, "_se"}, int'(step_err), 0);
    chk({nm, "_err"}, int'(err_cnt), 0);
    chk({nm, "_lk"}, int'(locked), 0);
  endtask

  initial begin
    int v0;
    n_chk   = 0;
    n_fail  = 0;
    n_valid = 0;
    prev_v  = 1'b0;
    reset_model();
    rst_n = 1'b0;
    gray  = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");

    rst_n = 1'b1;
    expect_accept(0);
    repeat (3) @(posedge clk);
    #1 chk("init_no_valid_e3", int'(valid), 0);
    @(posedge clk);
    #1 chk("init_valid_e4", int'(valid), 1);
    chk("init_bin", int'(bin), 0);
    chk("init_lk", int'(locked), 1);
    chk("init_err", int'(err_cnt), 0);
    @(negedge clk);
    repeat (10) @(negedge clk);

    v0 = n_valid;
    for (int b = 1; b <= MSK; b++) drive(b, 6);
    drive(0, 6);
    drain("seq_drain");
    chk("seq_pulses", n_valid - v0, MSK + 1);
    chk("seq_dir", int'(dir), 1);
    chk("seq_err", int'(err_cnt), 0);

    for (int b = 1; b <= 5; b++) drive(b, 6);
    drain("to5_drain");
    v0 = n_valid;
    glitch(6, 2);
    glitch(6, 3);
    chk("glitch_pulses", n_valid - v0, 0);
    chk("glitch_bin", int'(bin), 5);

    drive(4, 8);
    drain("down_drain");
    chk("down_dir", int'(dir), 0);
    drive(9, 8);
    drain("jump_drain");
    chk("jump_bin", int'(bin), 9);
    chk("jump_err", int'(err_cnt), 1);
    chk("jump_dir", int'(dir), 0);

    drive(9, 10);
    chk("hold_pulses", n_valid - v0, 2);

    for (int i = 0; i < 300; i++) drive(((i % 2) == 0) ? 521 : 9, 6);
    drain("sat_drain");
    chk("sat_err", int'(err_cnt), 255);
    drive(10, 8);
    drain("sat_hold_drain");
    chk("sat_hold", int'(err_cnt), 255);

    gray = b2g(37);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("midrst");
    reset_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_accept(37);
    drain("post_rst_drain");
    chk("post_rst_bin", int'(bin), 37);
    chk("post_rst_lk", int'(locked), 1);
    chk("post_rst_err", int'(err_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
